bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/bus_arbiter_rr_pick.sv | 28 ++
 rtl/bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_bus_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types for the RAM bus arbiter and its round-robin picker.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    // Low bit of a requester index selects the cache side of the CPU.
    localparam int ARB_REQ_D = 0;
    localparam int ARB_REQ_I = 1;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    logic [PW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Walk from the farthest candidate back to ptr so the nearest one wins.
        for (int k = N - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one RAM port among the data and instruction caches of CPUS CPUs.
// Define BUS_ARBITER_PERF_EN to build the per-requester completed-grant counters.
module bus_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [CPUS-1:0]         iREN,
    input  logic [CPUS-1:0]         dREN,
    input  logic [CPUS-1:0]         dWEN,
    input  word_t [CPUS-1:0]        iaddr,
    input  word_t [CPUS-1:0]        daddr,
    input  word_t [CPUS-1:0]        dstore,
    output logic [CPUS-1:0]         iwait,
    output logic [CPUS-1:0]         dwait,
    output word_t [CPUS-1:0]        iload,
    output word_t [CPUS-1:0]        dload,
    output logic                    ramREN,
    output logic                    ramWEN,
    output word_t                   ramaddr,
    output word_t                   ramstore,
    input  word_t                   ramload,
    input  ramstate_t               ramstate,
    output logic [2*CPUS-1:0][31:0] grant_cnt
);

    localparam int N  = 2 * CPUS;
    localparam int PW = $clog2(N);
    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

    arb_state_t    state_q, state_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  req;
    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic [CW-1:0] gnt_cpu;
    logic          gnt_is_instr;

    for (genvar c = 0; c < CPUS; c++) begin : g_req
        assign req[2*c + ARB_REQ_D] = dREN[c] | dWEN[c];
        assign req[2*c + ARB_REQ_I] = iREN[c];
        assign iload[c] = ramload;
        assign dload[c] = ramload;
    end

    assign gnt_cpu      = CW'(gnt_q >> 1);
    assign gnt_is_instr = (gnt_q[0] == 1'(ARB_REQ_I));

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = SERVE;
                    gnt_d   = pick_idx;
                end
            end
            SERVE: begin
                // A withdrawn request abandons the grant without touching RAM or the pointer.
                if (!req[gnt_q]) begin
                    state_d = IDLE;
                end else begin
                    if (gnt_is_instr) begin
                        ramaddr = iaddr[gnt_cpu];
                    end else begin
                        ramaddr  = daddr[gnt_cpu];
                        ramstore = dstore[gnt_cpu];
                        ramWEN   = dWEN[gnt_cpu];
                    end
                    ramREN = ~ramWEN;
                    if (ramstate == ACCESS) begin
                        state_d = IDLE;
                        ptr_d   = PW'(rr_next(int'(gnt_q), N));
                        if (gnt_is_instr) begin
                            iwait[gnt_cpu] = 1'b0;
                        end else begin
                            dwait[gnt_cpu] = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef BUS_ARBITER_PERF_EN
    logic [N-1:0][31:0] cnt_q, cnt_d;
    logic               done;

    always_comb begin
        done  = (state_q == SERVE) && req[gnt_q] && (ramstate == ACCESS);
        cnt_d = cnt_q;
        if (done) begin
            cnt_d[gnt_q] = cnt_q[gnt_q] + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter with a behavioural round-robin model and directed anchor cases.
module tb_bus_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;
    localparam int N    = 2 * CPUS;
`ifdef BUS_ARBITER_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic                 CLK = 1'b0;
    logic                 nRST = 1'b0;
    logic [CPUS-1:0]      iREN, dREN, dWEN;
    word_t [CPUS-1:0]     iaddr, daddr, dstore;
    logic [CPUS-1:0]      iwait, dwait;
    word_t [CPUS-1:0]     iload, dload;
    logic                 ramREN, ramWEN;
    word_t                ramaddr, ramstore, ramload;
    ramstate_t            ramstate;
    logic [N-1:0][31:0]   grant_cnt;

    bus_arbiter #(.CPUS(CPUS)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .iaddr     (iaddr),
        .daddr     (daddr),
        .dstore    (dstore),
        .iwait     (iwait),
        .dwait     (dwait),
        .iload     (iload),
        .dload     (dload),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate),
        .grant_cnt (grant_cnt)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: m_cur is the requester currently being served, -1 when nobody holds the bus.
    int          m_cur = -1;
    int          m_ptr = 0;
    logic [31:0] m_cnt [N] = '{default: 32'd0};

    bit log_en = 1'b0;
    int glog[$];
    int gcyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit mreq(input int r);
        int c = r / 2;
        if (r % 2 == ARB_REQ_I) return iREN[c];
        return dREN[c] | dWEN[c];
    endfunction

    function automatic int first_req(input int from);
        for (int k = 0; k < N; k++) begin
            if (mreq((from + k) % N)) return (from + k) % N;
        end
        return -1;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_cur <= -1;
            m_ptr <= 0;
            for (int r = 0; r < N; r++) m_cnt[r] <= 32'd0;
        end else if (m_cur < 0) begin
            m_cur <= first_req(m_ptr);
        end else if (!mreq(m_cur)) begin
            m_cur <= -1;
        end else if (ramstate == ACCESS) begin
            m_cnt[m_cur] <= m_cnt[m_cur] + 32'd1;
            m_ptr <= (m_cur + 1) % N;
            m_cur <= -1;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    initial begin
        int              cyc_n;
        bit              active;
        int              c;
        logic            exp_ren, exp_wen;
        word_t           exp_addr, exp_store;
        logic [CPUS-1:0] exp_iw, exp_dw;
        logic [31:0]     exp_cnt;
        cyc_n = 0;
        forever begin
            @(negedge CLK);
            cyc_n++;
            active    = (m_cur >= 0) && mreq(m_cur);
            exp_ren   = 1'b0;
            exp_wen   = 1'b0;
            exp_addr  = '0;
            exp_store = '0;
            exp_iw    = '1;
            exp_dw    = '1;
            if (active) begin
                c = m_cur / 2;
                if (m_cur % 2 == ARB_REQ_I) begin
                    exp_addr = iaddr[c];
                    exp_ren  = 1'b1;
                    if (ramstate == ACCESS) exp_iw[c] = 1'b0;
                end else begin
                    exp_addr  = daddr[c];
                    exp_store = dstore[c];
                    exp_wen   = dWEN[c];
                    exp_ren   = ~dWEN[c];
                    if (ramstate == ACCESS) exp_dw[c] = 1'b0;
                end
            end
            check("ramREN", 64'(ramREN), 64'(exp_ren));
            check("ramWEN", 64'(ramWEN), 64'(exp_wen));
            if (active || !nRST) begin
                check("ramaddr", 64'(ramaddr), 64'(exp_addr));
                check("ramstore", 64'(ramstore), 64'(exp_store));
            end
            check("iwait", 64'(iwait), 64'(exp_iw));
            check("dwait", 64'(dwait), 64'(exp_dw));
            for (int k = 0; k < CPUS; k++) begin
                check($sformatf("iload%0d", k), 64'(iload[k]), 64'(ramload));
                check($sformatf("dload%0d", k), 64'(dload[k]), 64'(ramload));
            end
            for (int r = 0; r < N; r++) begin
                exp_cnt = PERF_EN ? m_cnt[r] : 32'd0;
                check($sformatf("grant_cnt%0d", r), 64'(grant_cnt[r]), 64'(exp_cnt));
            end
            if (log_en) begin
                for (int k = 0; k < CPUS; k++) begin
                    if (!dwait[k]) begin glog.push_back(2*k + ARB_REQ_D); gcyc.push_back(cyc_n); end
                    if (!iwait[k]) begin glog.push_back(2*k + ARB_REQ_I); gcyc.push_back(cyc_n); end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0;
        ramstate = FREE;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        cyc();
        nRST = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        int w;
        clr();
        nRST = 1'b0;
        repeat (2) cyc();

        // Reset dominates even with every request present and RAM reporting ACCESS.
        dREN = '1; iREN = '1; ramstate = ACCESS; #1;
        check("rst_ren", 64'(ramREN), 64'd0);
        check("rst_wen", 64'(ramWEN), 64'd0);
        check("rst_dwait", 64'(dwait), 64'h3);
        check("rst_iwait", 64'(iwait), 64'h3);
        check("rst_addr", 64'(ramaddr), 64'd0);
        cyc();
        clr();
        nRST = 1'b1;

        // d0 read: two BUSY cycles, then ACCESS returns 0xDEADBEEF.
        dREN[0] = 1'b1; ramstate = BUSY; ramload = 32'hDEADBEEF; daddr[0] = 32'h44;
        cyc();
        cyc();
        cyc();
        ramstate = ACCESS; #1;
        check("d0_done_dwait", 64'(dwait), 64'h2);
        check("d0_done_dload", 64'(dload[0]), 64'hDEADBEEF);
        check("d0_done_ren", 64'(ramREN), 64'd1);
        cyc();
        dREN = '0; ramstate = FREE; #1;
        check("d0_after_dwait", 64'(dwait), 64'h3);
        check("d0_model_ptr", 64'(m_ptr), 64'd1);

        // Everyone held continuously: strict rotation with one idle cycle between grants.
        do_reset();
        clr();
        dREN = '1; iREN = '1; ramstate = ACCESS;
        glog.delete(); gcyc.delete();
        log_en = 1'b1;
        repeat (10) cyc();
        log_en = 1'b0;
        clr();
        check("rr_grants", 64'(glog.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_order%0d", i), 64'(i < glog.size() ? glog[i] : -1), 64'(exp_ord[i]));
        end
        for (int i = 1; i < 5; i++) begin
            check($sformatf("rr_gap%0d", i), 64'(i < gcyc.size() ? gcyc[i] - gcyc[i-1] : -1), 64'd2);
        end

        // d1 write stays on the RAM bus until ACCESS.
        do_reset();
        clr();
        dWEN[1] = 1'b1; daddr[1] = 32'h100; dstore[1] = 32'h55AA; ramstate = BUSY;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("d1_wr_wen", 64'(ramWEN), 64'd1);
            check("d1_wr_ren", 64'(ramREN), 64'd0);
            check("d1_wr_addr", 64'(ramaddr), 64'h100);
            check("d1_wr_store", 64'(ramstore), 64'h55AA);
        end
        ramstate = ACCESS; #1;
        check("d1_wr_dwait", 64'(dwait), 64'h1);
        cyc();
        clr();

        // i0 withdraws mid-grant: no completion, pointer stays at 0.
        do_reset();
        clr();
        iREN[0] = 1'b1; iaddr[0] = 32'h40; ramstate = BUSY;
        cyc();
        check("i0_drop_addr", 64'(ramaddr), 64'h40);
        iREN[0] = 1'b0; ramstate = ACCESS; #1;
        check("i0_drop_iwait", 64'(iwait), 64'h3);
        cyc();
        check("i0_drop_iwait2", 64'(iwait), 64'h3);
        check("i0_drop_model_ptr", 64'(m_ptr), 64'd0);
        iREN[0] = 1'b1; dREN[1] = 1'b1;
        cyc();
        check("i0_drop_regrant_iwait", 64'(iwait), 64'h2);
        check("i0_drop_regrant_dwait", 64'(dwait), 64'h3);
        cyc();
        clr();

        // Reset in the middle of a SERVE returns the pointer to 0.
        do_reset();
        clr();
        dREN[0] = 1'b1; ramstate = ACCESS;
        cyc();
        cyc();
        clr();
        dWEN[1] = 1'b1; daddr[1] = 32'h200; ramstate = BUSY;
        cyc();
        check("mid_rst_pre_wen", 64'(ramWEN), 64'd1);
        nRST = 1'b0; #1;
        check("mid_rst_wen", 64'(ramWEN), 64'd0);
        check("mid_rst_ren", 64'(ramREN), 64'd0);
        check("mid_rst_addr", 64'(ramaddr), 64'd0);
        check("mid_rst_dwait", 64'(dwait), 64'h3);
        check("mid_rst_cnt0", 64'(grant_cnt[0]), 64'd0);
        cyc();
        nRST = 1'b1;
        clr();
        dREN[0] = 1'b1; iREN[0] = 1'b1; ramstate = ACCESS;
        cyc();
        check("mid_rst_regrant_dwait", 64'(dwait), 64'h2);
        check("mid_rst_regrant_iwait", 64'(iwait), 64'h3);
        cyc();
        clr();

        // Three d0 completions.
        do_reset();
        clr();
        dREN[0] = 1'b1; ramstate = ACCESS;
        repeat (6) cyc();
        clr(); #1;
        check("cnt_d0", 64'(grant_cnt[0]), PERF_EN ? 64'd3 : 64'd0);
        for (int r = 1; r < N; r++) begin
            check($sformatf("cnt_other%0d", r), 64'(grant_cnt[r]), 64'd0);
        end

        // Randomized traffic with sticky requests and occasional asynchronous resets.
        do_reset();
        clr();
        repeat (3000) begin
            cyc();
            nRST = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            for (int c = 0; c < CPUS; c++) begin
                if ($urandom_range(0, 7) == 0) iREN[c] = ~iREN[c];
                if ($urandom_range(0, 7) == 0) begin
                    if (dREN[c] | dWEN[c]) begin
                        dREN[c] = 1'b0;
                        dWEN[c] = 1'b0;
                    end else begin
                        w = $urandom_range(0, 1);
                        dWEN[c] = w[0];
                        dREN[c] = ~w[0];
                    end
                end
                iaddr[c]  = $urandom;
                daddr[c]  = $urandom;
                dstore[c] = $urandom;
            end
            w = $urandom_range(0, 5);
            ramstate = ramstate_t'((w > 3) ? 2 : w);
            ramload  = $urandom;
        end
        nRST = 1'b1;
        clr();
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
